mem_port_arbiter: RTL

- Shares the single DPI-backed data memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- Keeps one transaction outstanding at a time.
- Gives LSU fixed priority, with a starvation guard that forces an IF grant after STARVE_LIMIT consecutive LSU grants while IF waits.
- Sits between the fetch/memory stages and the memory model wrapper, which drives pmem_read/pmem_write.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between IF (read) and LSU (read/write),
//            one outstanding transaction, LSU priority with IF starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rdata,
    // load/store unit
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [7:0]      lsu_wmask,
    output logic            lsu_rsp_valid,
    output logic [XLEN-1:0] lsu_rdata,
    // memory side
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [3:0]        starve_q, starve_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;

    logic              grant_if;
    logic              grant_lsu;
    logic              rsp_fire;

    assign grant_if  = if_req_valid & (~lsu_req_valid | (starve_q == C_STARVE_LIMIT));
    assign grant_lsu = lsu_req_valid & ~grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            starve_q    <= 4'd0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        case (state_q)
            S_IDLE: begin
                if (grant_if) begin
                    owner_lsu_d = 1'b0;
                    starve_d    = 4'd0;
                    addr_d      = if_addr;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = 8'd0;
                    state_d     = S_REQ;
                end else if (grant_lsu) begin
                    owner_lsu_d = 1'b1;
                    // only counts as starving IF when IF was actually waiting
                    if (if_req_valid && (starve_q != C_STARVE_LIMIT)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    addr_d      = lsu_addr;
                    wen_d       = lsu_wen;
                    wdata_d     = lsu_wdata;
                    wmask_d     = lsu_wen ? lsu_wmask : 8'd0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign if_req_ready  = (state_q == S_IDLE) & grant_if;
    assign lsu_req_ready = (state_q == S_IDLE) & grant_lsu;

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Responses outside RSP are ignored; read data is zeroed when not valid.
    assign rsp_fire      = (state_q == S_RSP) & mem_rsp_valid;
    assign if_rsp_valid  = rsp_fire & ~owner_lsu_q;
    assign lsu_rsp_valid = rsp_fire & owner_lsu_q;
    assign if_rdata      = if_rsp_valid  ? mem_rdata : '0;
    assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;

endmodule
`default_nettype wire
